audio_preemphasis: RTL and testbench

AUDIO_PREEMPHASIS -- requirements
Module: audio_preemphasis

---
 rtl/audio_preemphasis.sv | 139 +++++++++++++
 tb/tb_audio_preemphasis.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_preemphasis.sv
// Audio pre-emphasis: y = sat_A(x + (((x - x_prev) * c) >>> S)) using a serial LSB-first shift-add multiplier.
// Define AUDIO_PREEMPHASIS_CLIP_CNT_EN to build the 8-bit saturating clip event counter.
module audio_preemphasis #(
   parameter int A = 8,
   parameter int K = 4,
   parameter int S = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [A-1:0] audio_in,
   input  logic         audio_dv,
   input  logic [K-1:0] coef,
   input  logic         bypass,
   output logic [A-1:0] audio_out,
   output logic         out_dv,
   output logic         busy,
   output logic         clip,
   output logic [7:0]   clip_cnt
);
   localparam int P  = A + 1 + K;
   localparam int SW = A + 2 + K;
   localparam int CW = $clog2(K + 1);

   typedef enum logic [1:0] {IDLE, MUL, SAT, OUT} state_t;
   state_t state_q, state_d;

   logic signed [A-1:0]  x_q, x_prev_q, y_q;
   logic signed [P-1:0]  md_q, acc_q, acc_sh;
   logic        [K-1:0]  c_q;
   logic        [CW-1:0] cnt_q;
   logic                 clip_pend_q;
   logic        [A-1:0]  audio_out_q;
   logic                 out_dv_q, clip_q;
   logic                 mul_last;
   logic signed [A:0]    d_w;
   logic signed [SW-1:0] sum_w;

   function automatic logic signed [A-1:0] sat_a(input logic signed [SW-1:0] v);
      logic signed [SW-1:0] hi, lo;
      hi = SW'((2 ** (A - 1)) - 1);
      lo = ~hi;
      if (v > hi)      sat_a = hi[A-1:0];
      else if (v < lo) sat_a = lo[A-1:0];
      else             sat_a = v[A-1:0];
   endfunction

   function automatic logic is_clip(input logic signed [SW-1:0] v);
      logic signed [SW-1:0] hi, lo;
      hi = SW'((2 ** (A - 1)) - 1);
      lo = ~hi;
      is_clip = (v > hi) || (v < lo);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (audio_dv) state_d = MUL;
         MUL:     if (mul_last) state_d = SAT;
         SAT:     state_d = OUT;
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != IDLE);
      mul_last = (state_q == MUL) && (cnt_q == CW'(K - 1));
   end

   // Difference is taken against x_prev at latch time; the sum is sign-extended to full width.
   assign d_w    = $signed({audio_in[A-1], audio_in}) - $signed({x_prev_q[A-1], x_prev_q});
   assign acc_sh = acc_q >>> S;
   assign sum_w  = $signed({{(K + 2){x_q[A-1]}}, x_q}) + $signed({acc_sh[P-1], acc_sh});

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         x_prev_q    <= '0;
         audio_out_q <= '0;
         out_dv_q    <= 1'b0;
         clip_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         out_dv_q <= 1'b0;
         clip_q   <= 1'b0;
         case (state_q)
            IDLE: if (audio_dv) begin
               x_q   <= $signed(audio_in);
               c_q   <= bypass ? '0 : coef;
               md_q  <= {{K{d_w[A]}}, d_w};
               acc_q <= '0;
               cnt_q <= '0;
            end
            MUL: begin
               if (c_q[0]) acc_q <= acc_q + md_q;
               md_q  <= md_q <<< 1;
               c_q   <= c_q >> 1;
               cnt_q <= cnt_q + CW'(1);
            end
            SAT: begin
               y_q         <= sat_a(sum_w);
               clip_pend_q <= is_clip(sum_w);
            end
            OUT: begin
               audio_out_q <= y_q;
               out_dv_q    <= 1'b1;
               clip_q      <= clip_pend_q;
               x_prev_q    <= x_q;
            end
            default: ;
         endcase
      end
   end

   assign audio_out = audio_out_q;
   assign out_dv    = out_dv_q;
   assign clip      = clip_q;

`ifdef AUDIO_PREEMPHASIS_CLIP_CNT_EN
   logic [7:0] clip_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         clip_cnt_q <= '0;
      else if (state_q == OUT && clip_pend_q && clip_cnt_q != 8'hFF)
         clip_cnt_q <= clip_cnt_q + 8'd1;
   end

   assign clip_cnt = clip_cnt_q;
`else
   assign clip_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_preemphasis.sv
// Scoreboard bench for audio_preemphasis: an integer reference model pushes expectations per accepted strobe.
module tb_audio_preemphasis;
   localparam int A = 8;
   localparam int K = 4;
   localparam int S = 2;
`ifdef AUDIO_PREEMPHASIS_CLIP_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [A-1:0]        audio_in = '0;
   logic                audio_dv = 1'b0;
   logic [K-1:0]        coef = '0;
   logic                bypass = 1'b0;
   logic signed [A-1:0] audio_out;
   logic                out_dv, busy, clip;
   logic [7:0]          clip_cnt;

   always #5 clk = ~clk;

   audio_preemphasis #(.A(A), .K(K), .S(S)) dut (
      .clk(clk), .rst(rst), .audio_in(audio_in), .audio_dv(audio_dv),
      .coef(coef), .bypass(bypass), .audio_out(audio_out), .out_dv(out_dv),
      .busy(busy), .clip(clip), .clip_cnt(clip_cnt)
   );

   typedef struct {int val; int clp; int cyc;} exp_t;
   exp_t sb[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit rst_at_edge = 1'b0;
   int tb_xp = 0;
   int mdl_out = 0;
   int mdl_cnt = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= rst;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_at_edge) begin
         mdl_out = 0;
         mdl_cnt = 0;
      end
      if (out_dv) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_dv", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("out_val", int'(audio_out), e.val);
            chk("out_clip", int'(clip), e.clp);
            chk("latency", cyc - e.cyc, 7);
            mdl_out = e.val;
            if (CNT_EN && e.clp != 0 && mdl_cnt < 255) mdl_cnt++;
            chk("clip_cnt", int'(clip_cnt), mdl_cnt);
         end
      end else begin
         chk("clip_idle", int'(clip), 0);
         chk("hold", int'(audio_out), mdl_out);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x, input int c, input bit byp, input bit acc);
      int ce, p, s;
      exp_t e;
      audio_in = x[A-1:0];
      coef     = c[K-1:0];
      bypass   = byp;
      audio_dv = 1'b1;
      if (acc) begin
         ce = byp ? 0 : c;
         p  = (x - tb_xp) * ce;
         s  = x + (p >>> S);
         e.clp = (s > 127 || s < -128) ? 1 : 0;
         e.val = (s > 127) ? 127 : (s < -128) ? -128 : s;
         e.cyc = cyc;
         sb.push_back(e);
         tb_xp = x;
      end
      tick();
      audio_dv = 1'b0;
      coef     = K'($urandom_range(0, 15));
      bypass   = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst   = 1'b0;
      tb_xp = 0;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_audio_out", int'(audio_out), 0);
      chk("rst_out_dv", int'(out_dv), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_clip", int'(clip), 0);
      chk("rst_clip_cnt", int'(clip_cnt), 0);
      rst = 1'b0;
      tick();

      // basic gain and both saturation directions
      send(10, 4, 1'b0, 1'b1);
      chk("busy_in_mul", int'(busy), 1);
      drain();
      send(100, 4, 1'b0, 1'b1);
      drain();
      send(-100, 4, 1'b0, 1'b1);
      drain();
      chk("cnt_after_sat", int'(clip_cnt), CNT_EN ? 2 : 0);

      // bypass, then floor rounding of a negative product
      send(-77, 15, 1'b1, 1'b1);
      drain();
      send(5, 0, 1'b1, 1'b1);
      drain();
      send(4, 1, 1'b0, 1'b1);
      drain();

      // overrun: second strobe three cycles later is dropped
      do_reset();
      send(10, 4, 1'b0, 1'b1);
      tick();
      tick();
      send(50, 4, 1'b0, 1'b0);
      drain();
      send(10, 4, 1'b0, 1'b1);
      drain();

      // strobe in the OUT cycle is dropped, next cycle is accepted
      send(40, 2, 1'b0, 1'b1);
      repeat (5) tick();
      send(-60, 3, 1'b0, 1'b0);
      send(-60, 3, 1'b0, 1'b1);
      drain();

      // reset mid-MUL aborts the sample
      send(33, 4, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      tb_xp = 0;
      chk("busy_after_abort", int'(busy), 0);
      repeat (10) tick();
      send(10, 4, 1'b0, 1'b1);
      drain();

      for (int i = 0; i < 30; i++) begin
         send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0), 1'b1);
         drain();
      end

      // counter saturation
      for (int i = 0; i < 300; i++) begin
         send((i % 2 == 0) ? 100 : -100, 4, 1'b0, 1'b1);
         drain();
      end
      chk("cnt_final", int'(clip_cnt), CNT_EN ? 255 : 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
